// File: rtl/rotary_led_pkg.sv
// Shared constants for the rotary encoder LED ring driver.
// Quadrature decoder states and display mode encodings.
package rotary_led_pkg;

    localparam logic [2:0] ST_REST   = 3'd0;
    localparam logic [2:0] ST_CW1    = 3'd1;
    localparam logic [2:0] ST_CW2    = 3'd2;
    localparam logic [2:0] ST_CW3    = 3'd3;
    localparam logic [2:0] ST_CCW1   = 3'd4;
    localparam logic [2:0] ST_CCW2   = 3'd5;
    localparam logic [2:0] ST_CCW3   = 3'd6;
    localparam logic [2:0] ST_RESYNC = 3'd7;

    localparam logic [1:0] MODE_DOT = 2'd0;
    localparam logic [1:0] MODE_BAR = 2'd1;
    localparam logic [1:0] MODE_OFF = 2'd2;
    localparam logic [1:0] MODE_ON  = 2'd3;

endpackage

// File: rtl/rotary_debounce.sv
// Two-flop synchroniser followed by a stable-count filter.
// The output flips after DEBOUNCE consecutive disagreeing cycles.
module rotary_debounce
    import rotary_led_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count disagreeing cycles; any agreeing cycle clears the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser chain and filter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/rotary_led_ring.sv
// Rotary encoder LED ring: debounce, quadrature decode,
// position counter and registered LED pattern.
module rotary_led_ring
    import rotary_led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4,
    parameter int WRAP     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ROT_A,
    input  logic                     ROT_B,
    input  logic                     ROT_CENTER,
    input  logic [1:0]               Mode,
    input  logic                     Switch,
    output logic [WIDTH-1:0]         LEDOut,
    output logic [$clog2(WIDTH)-1:0] Position,
    output logic                     StepCW,
    output logic                     StepCCW
);

    localparam int PW = $clog2(WIDTH);

    logic             a_f;
    logic             b_f;
    logic             c_f;
    logic [1:0]       ab_q;
    logic [2:0]       st_q;
    logic [2:0]       st_d;
    logic             cw_d;
    logic             ccw_d;
    logic             cw_q;
    logic             ccw_q;
    logic [PW-1:0]    pos_q;
    logic [PW-1:0]    pos_d;
    logic [WIDTH-1:0] dot;
    logic [WIDTH-1:0] bar;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] led_q;
    logic [WIDTH-1:0] led_d;

    rotary_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clk(clk), .rst(rst), .raw_i(ROT_A), .filt_o(a_f)
    );
    rotary_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clk(clk), .rst(rst), .raw_i(ROT_B), .filt_o(b_f)
    );
    rotary_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_c (
        .clk(clk), .rst(rst), .raw_i(ROT_CENTER), .filt_o(c_f)
    );

    // Quadrature decode; a step fires only on return to 00 from phase 3.
    always_comb begin
        st_d  = st_q;
        cw_d  = 1'b0;
        ccw_d = 1'b0;
        unique case (st_q)
            ST_REST: case (ab_q)
                2'b10:   st_d = ST_CW1;
                2'b01:   st_d = ST_CCW1;
                2'b11:   st_d = ST_RESYNC;
                default: ;
            endcase
            ST_CW1: case (ab_q)
                2'b11:   st_d = ST_CW2;
                2'b00:   st_d = ST_REST;
                2'b01:   st_d = ST_RESYNC;
                default: ;
            endcase
            ST_CW2: case (ab_q)
                2'b01:   st_d = ST_CW3;
                2'b10:   st_d = ST_CW1;
                2'b00:   st_d = ST_RESYNC;
                default: ;
            endcase
            ST_CW3: case (ab_q)
                2'b00: begin
                    st_d = ST_REST;
                    cw_d = 1'b1;
                end
                2'b11:   st_d = ST_CW2;
                2'b10:   st_d = ST_RESYNC;
                default: ;
            endcase
            ST_CCW1: case (ab_q)
                2'b11:   st_d = ST_CCW2;
                2'b00:   st_d = ST_REST;
                2'b10:   st_d = ST_RESYNC;
                default: ;
            endcase
            ST_CCW2: case (ab_q)
                2'b10:   st_d = ST_CCW3;
                2'b01:   st_d = ST_CCW1;
                2'b00:   st_d = ST_RESYNC;
                default: ;
            endcase
            ST_CCW3: case (ab_q)
                2'b00: begin
                    st_d  = ST_REST;
                    ccw_d = 1'b1;
                end
                2'b11:   st_d = ST_CCW2;
                2'b01:   st_d = ST_RESYNC;
                default: ;
            endcase
            default: begin
                if (ab_q == 2'b00) st_d = ST_REST;
            end
        endcase
    end

    // Next position: button clears, otherwise step with wrap or saturate.
    always_comb begin
        pos_d = pos_q;
        if (c_f) begin
            pos_d = '0;
        end else if (cw_d) begin
            if (pos_q == PW'(WIDTH - 1)) begin
                pos_d = (WRAP != 0) ? '0 : pos_q;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end else if (ccw_d) begin
            if (pos_q == '0) begin
                pos_d = (WRAP != 0) ? PW'(WIDTH - 1) : pos_q;
            end else begin
                pos_d = pos_q - 1'b1;
            end
        end
    end

    // LED pattern from the registered position, then optional inversion.
    always_comb begin
        dot = '0;
        bar = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dot[i] = (PW'(i) == pos_q);
            bar[i] = (PW'(i) <= pos_q);
        end
        unique case (Mode)
            MODE_DOT: pat = dot;
            MODE_BAR: pat = bar;
            MODE_OFF: pat = '0;
            default:  pat = '1;
        endcase
        led_d = pat ^ {WIDTH{Switch}};
    end

    // Decoder input stage, FSM, step pulses, position and LED registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ab_q  <= 2'b00;
            st_q  <= ST_REST;
            cw_q  <= 1'b0;
            ccw_q <= 1'b0;
            pos_q <= '0;
            led_q <= '0;
        end else begin
            ab_q  <= {a_f, b_f};
            st_q  <= st_d;
            cw_q  <= cw_d;
            ccw_q <= ccw_d;
            pos_q <= pos_d;
            led_q <= led_d;
        end
    end

    assign LEDOut   = led_q;
    assign Position = pos_q;
    assign StepCW   = cw_q;
    assign StepCCW  = ccw_q;

endmodule

// File: doc/rotary_led_ring.md
# rotary_led_ring

Parametrised rotary-encoder LED ring driver: synchronises and debounces the quadrature inputs and the push-button, decodes full detent steps with a state machine, and keeps a position counter over a ring of `WIDTH` LEDs. It renders the position as a dot, a bar, or a lamp-test pattern, with optional inversion. It replaces the unclocked level-sensitive rotator in the front-panel path and drives the board LEDs directly.

## Interface
Parameters:
- `WIDTH`, 8: number of LEDs (≥2); position range 0..WIDTH-1.
- `DEBOUNCE`, 4: consecutive stable cycles required before a filtered input changes (≥1).
- `WRAP`, 1: 1 = position wraps modulo WIDTH; 0 = position saturates at 0 / WIDTH-1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ROT_A`  in  1  raw encoder channel A, asynchronous.
- `ROT_B`  in  1  raw encoder channel B, asynchronous.
- `ROT_CENTER`  in  1  raw push-button, active-high, asynchronous.
- `Mode`  in  2  display mode: 0 dot, 1 bar, 2 all off, 3 all on.
- `Switch`  in  1  1 = invert LED output.
- `LEDOut`  out  WIDTH  registered LED drive.
- `Position`  out  clog2(WIDTH)  current position.
- `StepCW`  out  1  one-cycle pulse per completed clockwise detent.
- `StepCCW`  out  1  one-cycle pulse per completed counter-clockwise detent.

## Operation
- Each raw input: 2-flop synchroniser, then filter. Filter output changes only after the synchronised value differs from it for `DEBOUNCE` consecutive cycles. Any agreeing cycle clears the count.
- Quadrature FSM on filtered {A,B}. The rest/detent code is 00.
  - States: REST, CW1(10), CW2(11), CW3(01), CCW1(01), CCW2(11), CCW3(10), RESYNC.
  - CW sequence: 00→10→11→01→00. Reaching 00 from CW3 pulses StepCW.
  - CCW sequence: 00→01→11→10→00. Reaching 00 from CCW3 pulses StepCCW.
  - Single-bit backtrack within a sequence returns to the previous state. 00 from CW1/CCW1 returns to REST with no step.
  - Two-bit change (illegal jump) → RESYNC. RESYNC exits to REST only when the input is 00. No step is emitted from RESYNC.
- Position update:
  - StepCW: +1. StepCCW: −1.
  - WRAP=1: WIDTH-1+1 → 0 and 0−1 → WIDTH-1.
  - WRAP=0: holds at the limits; the step pulse is still emitted.
  - Filtered ROT_CENTER high: Position ← 0, taking priority over a step in the same cycle.
- LEDOut pattern, computed from the registered Position, then XOR with {WIDTH{Switch}}:
  - Mode 0: one-hot bit[Position].
  - Mode 1: bits [Position:0] set.
  - Mode 2: all zeros.
  - Mode 3: all ones.
- Mode and Switch are used as synchronous level controls without a synchroniser. The board provides static DIP switches.

## Timing
- Reset values: Position 0, LEDOut 0, StepCW/StepCCW 0, FSM REST, synchronisers 0, filtered values 0, debounce counters 0.
- After reset, LEDOut shows the pattern from the second edge onward.
- Latency: let edge t be the first edge at which the final raw transition to 00 is sampled. Then:
  - StepCW/StepCCW go high and Position updates at edge t+DEBOUNCE+3.
  - LEDOut reflects the new Position at edge t+DEBOUNCE+4.
- Mode/Switch change → LEDOut at the next edge.
- Reset asserted mid-sequence: the FSM returns to REST and no step is emitted for the partial sequence.
- At most one step pulse per cycle. StepCW and StepCCW are never high together.

## Structure
- Package `rotary_led_pkg`: FSM state enumeration, Mode encoding constants (MODE_DOT, MODE_BAR, MODE_OFF, MODE_ON).
- Sub-module `rotary_debounce`, parameter DEBOUNCE: synchroniser plus filter, one input and one output. Instantiated three times (A, B, CENTER).
- Top level holds the FSM, the position counter and the pattern register.

## Test plan
All scenarios use WIDTH=8, DEBOUNCE=4.
- Reset, Mode=0, Switch=0 → LEDOut 0x00, then 0x01; Position 0.
- Three clean CW detents, each phase held 10 cycles → three StepCW pulses; Position 3; LEDOut 0x08. Check the step occurs exactly 7 cycles after sampling 00.
- Position 0, one CCW detent: WRAP=1 → Position 7, LEDOut 0x80. WRAP=0 → Position 0 with the StepCCW pulse still emitted.
- Bounce: glitch A for 3 cycles (shorter than DEBOUNCE) during REST → no FSM change, no step. Then jump 00→11 → RESYNC, no step until 00 is seen and a clean detent completes.
- Position 5, Mode=1 → 0x3F. Switch=1 → 0xC0. Mode=3 → 0x00 (inverted all-on). Mode=2, Switch=0 → 0x00.
- ROT_CENTER press coincident with the final CW transition → Position 0 (press wins). Assert `rst` after CW2 → REST, no pulse after reset.
